// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl: HS burst sequencer sending a sync byte and then PRBS payload bytes.
// Define PRBS_BURST_CTRL_TRAIL_EN to add two trail bytes after the payload.
module prbs_burst_ctrl #(
  parameter int         BURST_W   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
  input  logic               Clk,
  input  logic               TxRst,
  input  logic               Start,
  input  logic [BURST_W-1:0] BurstLen,
  input  logic               Abort,
  input  logic [7:0]         PRBS_Pattern,
  output logic               PRBS_Enable,
  input  logic               TxReadyHS,
  output logic               TxRequestHS,
  output logic [7:0]         TxDataHS,
  output logic               Busy,
  output logic               Done,
  output logic [BURST_W-1:0] ByteCount
);
`ifdef PRBS_BURST_CTRL_TRAIL_EN
  typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, TRAIL, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, DONE} state_t;
`endif
  state_t state_q;
  logic [BURST_W-1:0] len_q, cnt_q;
  logic tx_act, xfer, last;
  logic [7:0] trail_byte;
`ifdef PRBS_BURST_CTRL_TRAIL_EN
  logic trl_q, bit_q;
  assign tx_act = state_q == SYNC || state_q == PAYLOAD || state_q == TRAIL;
  assign trail_byte = {8{bit_q}};
`else
  assign tx_act = state_q == SYNC || state_q == PAYLOAD;
  assign trail_byte = 8'h00;
`endif
  // Reset and Abort both suppress any handshake in the cycle they are seen
  assign TxRequestHS = !TxRst && tx_act;
  assign xfer = TxRequestHS && TxReadyHS && !Abort;
  assign PRBS_Enable = xfer && state_q == PAYLOAD;
  assign last = cnt_q == len_q - BURST_W'(1);
  assign Busy = !TxRst && state_q != IDLE;
  assign Done = !TxRst && !Abort && state_q == DONE;
  assign ByteCount = cnt_q;
  assign TxDataHS = TxRst ? 8'h00 : state_q == SYNC ? SYNC_BYTE :
                    state_q == PAYLOAD ? PRBS_Pattern : tx_act ? trail_byte : 8'h00;
  always_ff @(posedge Clk) begin
    if (TxRst) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
`ifdef PRBS_BURST_CTRL_TRAIL_EN
      trl_q <= 1'b0;
      bit_q <= 1'b0;
`endif
    end else if (Abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          len_q <= BurstLen;
          cnt_q <= '0;
          state_q <= BurstLen != '0 ? SYNC : DONE;
        end
        SYNC: if (xfer) state_q <= PAYLOAD;
        PAYLOAD: if (xfer) begin
          if (cnt_q != len_q) cnt_q <= cnt_q + BURST_W'(1);
          if (last) begin
`ifdef PRBS_BURST_CTRL_TRAIL_EN
            state_q <= TRAIL;
            bit_q <= ~PRBS_Pattern[7];
            trl_q <= 1'b0;
`else
            state_q <= DONE;
`endif
          end
        end
`ifdef PRBS_BURST_CTRL_TRAIL_EN
        TRAIL: if (xfer) begin
          trl_q <= !trl_q;
          if (trl_q) state_q <= DONE;
        end
`endif
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// tb_prbs_burst_ctrl: directed bench for prbs_burst_ctrl with a table-driven pattern generator.
module tb_prbs_burst_ctrl;
  logic Clk = 1'b0;
  logic TxRst, Start, Abort, TxReadyHS;
  logic [15:0] BurstLen;
  logic [7:0] PRBS_Pattern;
  logic PRBS_Enable, TxRequestHS, Busy, Done;
  logic [7:0] TxDataHS;
  logic [15:0] ByteCount;
  logic [7:0] pat [32];
  logic [4:0] idx = '0;
  logic [4:0] e = '0;
  int passed = 0;
  int total = 0;

  prbs_burst_ctrl dut (
    .Clk(Clk), .TxRst(TxRst), .Start(Start), .BurstLen(BurstLen), .Abort(Abort),
    .PRBS_Pattern(PRBS_Pattern), .PRBS_Enable(PRBS_Enable), .TxReadyHS(TxReadyHS),
    .TxRequestHS(TxRequestHS), .TxDataHS(TxDataHS), .Busy(Busy), .Done(Done),
    .ByteCount(ByteCount)
  );

  always #5 Clk = ~Clk;
  assign PRBS_Pattern = pat[idx];
  always @(posedge Clk) if (PRBS_Enable) idx <= idx + 5'd1;

  task automatic test_reset();
    TxRst = 1; TxReadyHS = 1;
    repeat (5) @(negedge Clk);
    #1;
    total++; if (PRBS_Enable !== 1'b0) $display("FAIL rst_en got %b want 0", PRBS_Enable); else passed++;
    total++; if (TxRequestHS !== 1'b0) $display("FAIL rst_req got %b want 0", TxRequestHS); else passed++;
    total++; if (TxDataHS !== 8'h00) $display("FAIL rst_data got %h want 00", TxDataHS); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL rst_busy got %b want 0", Busy); else passed++;
    total++; if (Done !== 1'b0) $display("FAIL rst_done got %b want 0", Done); else passed++;
    total++; if (ByteCount !== 16'd0) $display("FAIL rst_cnt got %0d want 0", ByteCount); else passed++;
    TxRst = 0; TxReadyHS = 0;
  endtask

  task automatic test_burst();
    int en = 0;
    @(negedge Clk); Start = 1; BurstLen = 4; TxReadyHS = 1;
    @(negedge Clk); Start = 0; #1;
    total++; if (TxRequestHS !== 1'b1) $display("FAIL sync_req got %b want 1", TxRequestHS); else passed++;
    total++; if (TxDataHS !== 8'hB8) $display("FAIL sync_data got %h want b8", TxDataHS); else passed++;
    total++; if (PRBS_Enable !== 1'b0) $display("FAIL sync_en got %b want 0", PRBS_Enable); else passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk); #1;
      total++; if (TxDataHS !== pat[e]) $display("FAIL burst_data%0d got %h want %h", k, TxDataHS, pat[e]); else passed++;
      if (PRBS_Enable === 1'b1) en++;
      e++;
    end
    total++; if (en !== 4) $display("FAIL burst_en_pulses got %0d want 4", en); else passed++;
    @(negedge Clk); #1;
    total++; if (Done !== 1'b1) $display("FAIL burst_done got %b want 1", Done); else passed++;
    total++; if (TxRequestHS !== 1'b0) $display("FAIL burst_done_req got %b want 0", TxRequestHS); else passed++;
    total++; if (ByteCount !== 16'd4) $display("FAIL burst_cnt got %0d want 4", ByteCount); else passed++;
    @(negedge Clk); #1;
    total++; if (Done !== 1'b0) $display("FAIL burst_done_once got %b want 0", Done); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL burst_idle got %b want 0", Busy); else passed++;
    TxReadyHS = 0;
  endtask

  task automatic test_stall();
    @(negedge Clk); Start = 1; BurstLen = 3; TxReadyHS = 1;
    @(negedge Clk); Start = 0; #1;
    total++; if (TxDataHS !== 8'hB8) $display("FAIL stall_sync got %h want b8", TxDataHS); else passed++;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk); TxReadyHS = (c % 2) == 1; #1;
      total++; if (TxDataHS !== pat[e]) $display("FAIL stall_data%0d got %h want %h", c, TxDataHS, pat[e]); else passed++;
      total++; if (PRBS_Enable !== TxReadyHS) $display("FAIL stall_en%0d got %b want %b", c, PRBS_Enable, TxReadyHS); else passed++;
      if (TxReadyHS) e++;
    end
    @(negedge Clk); TxReadyHS = 0; #1;
    total++; if (Done !== 1'b1) $display("FAIL stall_done got %b want 1", Done); else passed++;
    total++; if (ByteCount !== 16'd3) $display("FAIL stall_cnt got %0d want 3", ByteCount); else passed++;
    @(negedge Clk);
  endtask

  task automatic test_zero();
    @(negedge Clk); Start = 1; BurstLen = 0; TxReadyHS = 1; #1;
    total++; if (TxRequestHS !== 1'b0) $display("FAIL zero_req_idle got %b want 0", TxRequestHS); else passed++;
    @(negedge Clk); Start = 0; #1;
    total++; if (Done !== 1'b1) $display("FAIL zero_done got %b want 1", Done); else passed++;
    total++; if (TxRequestHS !== 1'b0) $display("FAIL zero_req got %b want 0", TxRequestHS); else passed++;
    total++; if (ByteCount !== 16'd0) $display("FAIL zero_cnt got %0d want 0", ByteCount); else passed++;
    total++; if (PRBS_Enable !== 1'b0) $display("FAIL zero_en got %b want 0", PRBS_Enable); else passed++;
    @(negedge Clk); #1;
    total++; if (Busy !== 1'b0) $display("FAIL zero_idle got %b want 0", Busy); else passed++;
    TxReadyHS = 0;
  endtask

  task automatic test_abort();
    @(negedge Clk); Start = 1; BurstLen = 10; TxReadyHS = 1;
    @(negedge Clk); Start = 0;
    repeat (5) begin @(negedge Clk); e++; end
    @(negedge Clk); Abort = 1; #1;
    total++; if (PRBS_Enable !== 1'b0) $display("FAIL abort_en got %b want 0", PRBS_Enable); else passed++;
    @(negedge Clk); Abort = 0; #1;
    total++; if (TxRequestHS !== 1'b0) $display("FAIL abort_req got %b want 0", TxRequestHS); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL abort_busy got %b want 0", Busy); else passed++;
    total++; if (Done !== 1'b0) $display("FAIL abort_done got %b want 0", Done); else passed++;
    total++; if (ByteCount !== 16'd5) $display("FAIL abort_cnt got %0d want 5", ByteCount); else passed++;
    total++; if (PRBS_Pattern !== pat[e]) $display("FAIL abort_gen got %h want %h", PRBS_Pattern, pat[e]); else passed++;
    @(negedge Clk); Start = 1; BurstLen = 2;
    @(negedge Clk); Start = 1; BurstLen = 7; #1;
    total++; if (TxDataHS !== 8'hB8) $display("FAIL restart_sync got %h want b8", TxDataHS); else passed++;
    total++; if (Busy !== 1'b1) $display("FAIL restart_busy got %b want 1", Busy); else passed++;
    @(negedge Clk); Start = 0; #1;
    total++; if (TxDataHS !== pat[e]) $display("FAIL restart_p0 got %h want %h", TxDataHS, pat[e]); else passed++;
    e++;
    @(negedge Clk); #1;
    total++; if (TxDataHS !== pat[e]) $display("FAIL restart_p1 got %h want %h", TxDataHS, pat[e]); else passed++;
    e++;
    @(negedge Clk); #1;
    total++; if (Done !== 1'b1) $display("FAIL restart_done got %b want 1", Done); else passed++;
    total++; if (ByteCount !== 16'd2) $display("FAIL restart_cnt got %0d want 2", ByteCount); else passed++;
    @(negedge Clk); TxReadyHS = 0;
  endtask

  task automatic test_rst_mid();
    @(negedge Clk); Start = 1; BurstLen = 6; TxReadyHS = 1;
    @(negedge Clk); Start = 0;
    repeat (2) begin @(negedge Clk); e++; end
    @(negedge Clk); TxRst = 1; Start = 1; BurstLen = 3; #1;
    total++; if (PRBS_Enable !== 1'b0) $display("FAIL rstmid_en got %b want 0", PRBS_Enable); else passed++;
    total++; if (TxRequestHS !== 1'b0) $display("FAIL rstmid_req_during got %b want 0", TxRequestHS); else passed++;
    @(negedge Clk); TxRst = 0; Start = 0; #1;
    total++; if (TxRequestHS !== 1'b0) $display("FAIL rstmid_req got %b want 0", TxRequestHS); else passed++;
    total++; if (TxDataHS !== 8'h00) $display("FAIL rstmid_data got %h want 00", TxDataHS); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", Busy); else passed++;
    total++; if (Done !== 1'b0) $display("FAIL rstmid_done got %b want 0", Done); else passed++;
    total++; if (ByteCount !== 16'd0) $display("FAIL rstmid_cnt got %0d want 0", ByteCount); else passed++;
    total++; if (PRBS_Pattern !== pat[e]) $display("FAIL rstmid_gen got %h want %h", PRBS_Pattern, pat[e]); else passed++;
    TxReadyHS = 0;
  endtask

`ifdef PRBS_BURST_CTRL_TRAIL_EN
  task automatic test_trail();
    for (int t = 0; t < 2; t++) begin
      pat[e] = t == 0 ? 8'h80 : 8'h01;
      @(negedge Clk); Start = 1; BurstLen = 1; TxReadyHS = 1;
      @(negedge Clk); Start = 0;
      @(negedge Clk); #1;
      total++; if (TxDataHS !== pat[e]) $display("FAIL trail_last%0d got %h want %h", t, TxDataHS, pat[e]); else passed++;
      e++;
      for (int j = 0; j < 2; j++) begin
        @(negedge Clk); #1;
        total++; if (TxDataHS !== (t == 0 ? 8'h00 : 8'hFF)) $display("FAIL trail_byte%0d_%0d got %h want %h", t, j, TxDataHS, t == 0 ? 8'h00 : 8'hFF); else passed++;
        total++; if (TxRequestHS !== 1'b1) $display("FAIL trail_req%0d_%0d got %b want 1", t, j, TxRequestHS); else passed++;
      end
      @(negedge Clk); #1;
      total++; if (Done !== 1'b1) $display("FAIL trail_done%0d got %b want 1", t, Done); else passed++;
      @(negedge Clk);
    end
    TxReadyHS = 0;
  endtask
`endif

  initial begin
    TxRst = 1; Start = 0; BurstLen = '0; Abort = 0; TxReadyHS = 0;
    for (int i = 0; i < 32; i++) pat[i] = 8'(i * 37 + 11);
    test_reset();
    test_burst();
    test_stall();
    test_zero();
    test_abort();
    test_rst_mid();
`ifdef PRBS_BURST_CTRL_TRAIL_EN
    test_trail();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/prbs_burst_ctrl.md
PRBS_BURST_CTRL -- requirements
Module: prbs_burst_ctrl

Interface
REQ-001 Parameter BURST_W, default 16, width of burst length and byte counter.
REQ-002 Parameter SYNC_BYTE, default 8'hB8, HS sync byte sent before payload.
REQ-003 Port Clk  in  1  single clock; all logic on rising edge.
REQ-004 Port TxRst  in  1  reset; synchronous and active-high.
REQ-005 Port Start  in  1  one-cycle burst request; sampled in IDLE only.
REQ-006 Port BurstLen  in  BURST_W  payload byte count; sampled with Start.
REQ-007 Port Abort  in  1  terminates the burst immediately.
REQ-008 Port PRBS_Pattern  in  8  current byte from the PRBS-9 generator.
REQ-009 Port PRBS_Enable  out  1  advance strobe to the PRBS-9 generator's Enable.
REQ-010 Port TxReadyHS  in  1  lane accepts the presented byte this cycle.
REQ-011 Port TxRequestHS  out  1  HS burst active; TxDataHS valid while high.
REQ-012 Port TxDataHS  out  8  byte presented to lane serializer.
REQ-013 Port Busy  out  1  high in any state other than IDLE.
REQ-014 Port Done  out  1  one-cycle pulse on normal burst completion.
REQ-015 Port ByteCount  out  BURST_W  payload bytes transferred in current/last burst.

Function
REQ-016 FSM states SHALL be IDLE, SYNC, PAYLOAD, TRAIL, DONE.
REQ-017 Transfer SHALL occur in a cycle where TxRequestHS=1 and TxReadyHS=1; TxDataHS held stable otherwise.
REQ-018 IDLE: Start=1 with BurstLen!=0 -> latch BurstLen, clear ByteCount, go SYNC next cycle.
REQ-019 IDLE: Start=1 with BurstLen=0 -> no HS request; go DONE (Done pulse one cycle later).
REQ-020 SYNC: TxRequestHS=1, TxDataHS=SYNC_BYTE; on transfer go PAYLOAD.
REQ-021 PAYLOAD: TxRequestHS=1, TxDataHS=PRBS_Pattern (combinational pass-through).
REQ-022 PAYLOAD: PRBS_Enable=1 exactly in transfer cycles, so generator advances one byte per accepted byte; PRBS_Enable=0 in all other states/cycles.
REQ-023 PAYLOAD transfer SHALL increment ByteCount; transfer when ByteCount=latched length-1 -> leave PAYLOAD (to TRAIL if enabled, else DONE).
REQ-024 DONE: TxRequestHS=0, Done=1 for exactly one cycle, then IDLE.
REQ-025 Start while Busy=1 SHALL be ignored; latched length unchanged.
REQ-026 Abort=1 in any non-IDLE state -> IDLE next cycle, TxRequestHS=0, no Done pulse, ByteCount retains value; Abort beats Start and a simultaneous transfer (transfer not counted, PRBS_Enable=0).
REQ-027 ByteCount SHALL saturate at latched length; no wrap-around.
REQ-028 TxReadyHS in IDLE/DONE SHALL be ignored.

Reset
REQ-029 TxRst=1 at a rising edge -> state IDLE, ByteCount=0, latched length=0, trail counter=0.
REQ-030 Outputs during/after reset: PRBS_Enable=0, TxRequestHS=0, TxDataHS=8'h00, Busy=0, Done=0.
REQ-031 Reset mid-burst SHALL behave as Abort plus counter clear; no Done pulse.

Configuration
REQ-032 Macro PRBS_BURST_CTRL_TRAIL_EN, when defined, SHALL compile in TRAIL state: after last payload byte, send 2 trail bytes, each all bits = ~TxDataHS[7] of last payload byte (captured at its transfer), then DONE.
REQ-033 Without PRBS_BURST_CTRL_TRAIL_EN, TRAIL state and capture register SHALL be absent; PAYLOAD exits directly to DONE.

Verification
REQ-034 Reset 5 cycles, Start with BurstLen=4, TxReadyHS=1 -> bytes B8, P0..P3 on consecutive cycles; 4 PRBS_Enable pulses; Done one cycle after last transfer; ByteCount=4.
REQ-035 BurstLen=3, TxReadyHS toggling 1,0,1,0 -> TxDataHS stable across stalls; PRBS_Enable only on ready cycles; payload equals 3 consecutive generator bytes.
REQ-036 BurstLen=0 -> TxRequestHS never high, Done pulses, ByteCount=0.
REQ-037 BurstLen=10, Abort after 5 payload transfers -> TxRequestHS low next cycle, no Done, ByteCount=5; new Start then succeeds.
REQ-038 TRAIL_EN defined, last payload byte 8'h80 -> two trail bytes 8'h00 before Done; last byte 8'h01 -> two 8'hFF.
REQ-039 TxRst asserted mid-PAYLOAD -> all outputs at reset values next cycle; Start during Busy ignored.
